// File: rtl/rgb_fader_if.sv
// rgb_fader_if: colour-select control and RGB/status bundle for rgb_fader (enable/colour/fade in, rgb/busy/done out)
interface rgb_fader_if #(parameter int CH_W = 8);
  logic              enable;
  logic [2:0]        colour;
  logic              fade;
  logic [3*CH_W-1:0] rgb;
  logic              busy;
  logic              done;
  modport master (output enable, colour, fade, input rgb, busy, done);
  modport slave  (input enable, colour, fade, output rgb, busy, done);
endinterface

// File: rtl/rgb_fader.sv
// rgb_fader: 3-bit colour index to packed {R,G,B}, snapping or ramping by STEP every DIV cycles (ports: clk, rst, bus)
module rgb_fader #(
  parameter int CH_W = 8,
  parameter int STEP = 16,
  parameter int DIV  = 4
) (
  input logic       clk,
  input logic       rst,
  rgb_fader_if.slave bus
);
  localparam int W  = 3 * CH_W;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CH_W-1:0] STEP_V = CH_W'(STEP);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0] tgt_q, tgt_d, rgb_q, rgb_d, dec, stepped;
  logic busy_q, busy_d, done_q, done_d, load, tick, settled;
  assign dec     = {{CH_W{bus.colour[2]}}, {CH_W{bus.colour[1]}}, {CH_W{bus.colour[0]}}};
  assign load    = bus.enable && dec != tgt_q;
  assign tick    = pre_q == PW'(DIV - 1);
  assign settled = stepped == tgt_q;
  // Each channel closes on its target by at most STEP; the distance test keeps the sum in range
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CH_W-1:0] cur, tgt;
    assign cur = rgb_q[c*CH_W +: CH_W];
    assign tgt = tgt_q[c*CH_W +: CH_W];
    assign stepped[c*CH_W +: CH_W] = cur < tgt ? (tgt - cur > STEP_V ? cur + STEP_V : tgt)
                                               : (cur - tgt > STEP_V ? cur - STEP_V : tgt);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tgt_q   <= '0;
      rgb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tgt_q   <= tgt_d;
      rgb_q   <= rgb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    if (bus.enable)
      state_d = state_q == IDLE ? (load && bus.fade ? RAMP : IDLE)
              : (!bus.fade || (!load && tick && settled)) ? IDLE : RAMP;
  end
  always_comb begin
    pre_d  = pre_q;
    tgt_d  = tgt_q;
    rgb_d  = rgb_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (bus.enable) begin
      if (state_q == IDLE) begin
        if (load) begin
          tgt_d  = dec;
          pre_d  = '0;
          busy_d = bus.fade;
          done_d = !bus.fade;
          rgb_d  = bus.fade ? rgb_q : dec;
        end
      end else if (!bus.fade) begin
        tgt_d  = load ? dec : tgt_q;
        rgb_d  = load ? dec : tgt_q;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else if (load) begin
        tgt_d = dec;
        pre_d = '0;
      end else if (tick) begin
        pre_d  = '0;
        rgb_d  = stepped;
        busy_d = !settled;
        done_d = settled;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end
  assign bus.rgb  = rgb_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: scoreboarded bench for rgb_fader at defaults (CH_W=8, STEP=16, DIV=4)
module tb_rgb_fader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rgb_fader_if #(.CH_W(8)) bus ();
  rgb_fader #(.CH_W(8), .STEP(16), .DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [23:0] sb_q[$];
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [23:0] rgb_of(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 300) begin
      tick();
      n++;
    end
    if (!bus.done) check("done_timeout", 0, 1);
  endtask
  always @(negedge clk)
    if (!rst && bus.done) begin
      done_cnt++;
      check("busy_with_done", {31'd0, bus.busy}, 0);
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else check("sb_rgb", bus.rgb, sb_q.pop_front());
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n, d0;
    logic [7:0] v;
    logic [23:0] hold;
    bus.enable = 1'b1;
    bus.colour = 3'd0;
    bus.fade   = 1'b0;
    #12;
    check("rst_rgb", bus.rgb, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("no_done_after_rst", done_cnt, 0);
    for (int c = 0; c < 8; c++) begin
      bus.colour = 3'(c);
      if (c != 0) sb_q.push_back(rgb_of(3'(c)));
      tick();
      check($sformatf("snap_%0d", c), bus.rgb, rgb_of(3'(c)));
      check($sformatf("snap_busy_%0d", c), {31'd0, bus.busy}, 0);
      tick();
    end
    check("snap_done_cnt", done_cnt, 7);
    bus.colour = 3'd0;
    sb_q.push_back(24'h000000);
    repeat (2) tick();
    d0 = done_cnt;
    bus.fade = 1'b1;
    bus.colour = 3'd7;
    sb_q.push_back(24'hFFFFFF);
    tick();
    check("fade_busy_load", {31'd0, bus.busy}, 1);
    check("fade_rgb_load", bus.rgb, 0);
    for (int i = 1; i <= 16; i++) begin
      repeat (4) tick();
      v = i * 16 > 255 ? 8'd255 : 8'(i * 16);
      check($sformatf("fade_tick_%0d", i), bus.rgb, {v, v, v});
      check($sformatf("fade_busy_%0d", i), {31'd0, bus.busy}, {31'd0, i < 16});
    end
    tick();
    check("fade_one_done", done_cnt - d0, 1);
    bus.fade = 1'b0;
    bus.colour = 3'd0;
    sb_q.push_back(24'h000000);
    repeat (2) tick();
    bus.fade = 1'b1;
    bus.colour = 3'd7;
    tick();
    repeat (20) tick();
    check("retgt_pre", bus.rgb, 24'h505050);
    d0 = done_cnt;
    bus.colour = 3'd2;
    sb_q.push_back(24'h00FF00);
    tick();
    repeat (4) tick();
    check("retgt_step1", bus.rgb, 24'h406040);
    check("retgt_busy", {31'd0, bus.busy}, 1);
    wait_done(n);
    check("retgt_latency", 4 + n, 44);
    tick();
    check("retgt_one_done", done_cnt - d0, 1);
    bus.colour = 3'd5;
    sb_q.push_back(24'hFF00FF);
    tick();
    repeat (10) tick();
    hold = bus.rgb;
    check("frz_pre", hold, 24'h20DF20);
    bus.enable = 1'b0;
    bus.colour = 3'd3;
    repeat (10) tick();
    check("frz_rgb_hold", bus.rgb, 24'h20DF20);
    check("frz_busy_hold", {31'd0, bus.busy}, 1);
    bus.colour = 3'd5;
    bus.enable = 1'b1;
    wait_done(n);
    check("frz_latency", 20 + n, 74);
    tick();
    bus.colour = 3'd6;
    sb_q.push_back(24'hFFFF00);
    tick();
    repeat (9) tick();
    check("abort_pre", bus.rgb, 24'hFF20DF);
    d0 = done_cnt;
    bus.fade = 1'b0;
    tick();
    check("abort_rgb", bus.rgb, 24'hFFFF00);
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 1);
    tick();
    check("abort_done_clr", {31'd0, bus.done}, 0);
    check("abort_one_done", done_cnt - d0, 1);
    bus.fade = 1'b1;
    bus.colour = 3'd1;
    tick();
    repeat (6) tick();
    check("mid_busy", {31'd0, bus.busy}, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("async_rgb", bus.rgb, 0);
    check("async_busy", {31'd0, bus.busy}, 0);
    check("async_done", {31'd0, bus.done}, 0);
    bus.colour = 3'd0;
    bus.fade = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_rgb", bus.rgb, 0);
    check("post_rst_no_done", done_cnt - d0, 0);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rgb_fader.md
# rgb_fader

Parametrised successor to the 3-bit colour converter. Maps a 3-bit colour index to a packed RGB word with configurable channel width. Output either snaps to the new colour or ramps each channel toward it in fixed steps at a prescaled rate. Sits between the colour-select control logic and the LED/display driver; it reports ramp progress through `busy` and a `done` pulse.

## Interface
Parameters:
- `CH_W`, default 8: bits per colour channel. Legal range 2..16.
- `STEP`, default 16: per-tick channel increment/decrement in fade mode. Legal range 1..2^CH_W-1.
- `DIV`, default 4: clock cycles per fade tick. Legal range ≥1.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `enable`  in  1: when low, the block freezes all state, ignores `colour`, and holds outputs.
- `colour`  in  3: colour index. Bit2 = R, bit1 = G, bit0 = B. Each set bit selects full scale (2^CH_W-1) for that channel; each clear bit selects 0.
- `fade`  in  1: 1 = ramp mode, 0 = snap mode. Sampled every enabled cycle.
- `rgb`  out  3*CH_W: registered output, packed {R,G,B}, R in the MSBs.
- `busy`  out  1: registered. High while `rgb` ≠ target.
- `done`  out  1: registered. One-cycle pulse when `rgb` reaches a newly loaded target.

## Operation
- Reset (async, any time, including mid-ramp):
  - `rgb`=0, target=0 (black), prescaler=0, `busy`=0, `done`=0.
  - State returns to IDLE.
- Target load:
  - On each enabled edge, `colour` is decoded into target.
  - A load occurs only if the decoded value differs from the current target.
  - Re-presenting the current target index is a no-op: no `busy`, no `done`.
- States: IDLE, RAMP.
- IDLE:
  - On a load with `fade`=0, `rgb` takes the new target at the same edge. `done`=1 for the next cycle. `busy` stays 0.
  - On a load with `fade`=1: target is registered, `busy`=1, prescaler cleared, go to RAMP.
- RAMP:
  - Prescaler counts 0..DIV-1 on enabled edges. A tick occurs on the edge where it equals DIV-1; it then wraps to 0.
  - On each tick, every channel moves toward its target by min(STEP, |target−current|).
  - Channels move independently; channels already equal stay put.
  - Arithmetic is done in CH_W bits and never wraps: clamp at target, no overflow past 2^CH_W-1 or underflow below 0.
  - On the tick at which all channels equal target: `busy`→0, `done`=1 for one cycle, go to IDLE.
  - Retarget mid-ramp (new load while in RAMP): target is replaced and the ramp continues from the current `rgb`. Prescaler restarts at 0, `busy` stays 1, and no `done` is issued for the abandoned target.
  - `fade` sampled 0 while in RAMP: at that edge `rgb`=target, `busy`→0, `done`=1 next cycle, go to IDLE.
  - A load and `fade`=0 on the same edge: snap to the new target.
- `enable` low:
  - Prescaler, state, target and `rgb` hold.
  - `done` is cleared after its single cycle regardless of `enable`.

## Timing
- Snap latency: `colour` changes before edge k → `rgb` valid after edge k; `done` high in cycle k..k+1.
- Fade latency:
  - Load at edge k → first step at edge k+DIV; step n lands at edge k+n·DIV.
  - Completion edge is k+N·DIV, where N = ceil(max channel distance / STEP).
  - `busy` falls and `done` rises at that completion edge.
- Defaults, black→white: N = ceil(255/16) = 16 ticks. Completion edge is k+64. R/G/B run 16, 32, …, 240, then 255 on the final step.
- DIV=1: one step per enabled cycle.
- Each cycle with `enable` low extends all latencies by exactly one cycle.
- `done` never stays high for more than one cycle. `busy` and `done` are never both high.

## Test plan
- Reset value check: assert `rst` mid-cycle while ramping → `rgb`=0, `busy`=0, `done`=0 immediately (async). After release with `colour`=0, no `done`.
- Snap all colours: `fade`=0, step `colour` 0..7, one per 2 cycles → `rgb` = {R,G,B} full/zero pattern one edge later (e.g. 5 → 0xFF00FF), with a `done` pulse each time.
- Fade black→white at defaults: `colour` 0→7, `fade`=1 → R/G/B = 16·n after tick n, 255 at tick 16. `busy` is high for 64 cycles; `done` pulses once at the completion edge.
- Retarget and decrement: fade to 7, then after 5 ticks (value 80) load 2 (green) → R/B ramp down 80→64…→0 and G continues up to 255. No `done` until all three settle; exactly one `done`.
- Enable freeze: drop `enable` for 10 cycles mid-ramp → `rgb`, `busy` and prescaler hold. Completion is delayed by exactly 10 cycles; `colour` changes during the freeze are ignored.
- Fade abort: in RAMP, drive `fade`=0 → `rgb`=target at that edge, `busy`=0, single `done` pulse.
